// File: rtl/seq_detect_ctrl_if.sv
// Control/config and serial-stream bundle for seq_detect_ctrl.
// master: config/control source and stream driver; slave: the detector.
interface seq_detect_ctrl_if #(
  parameter int unsigned MAXLEN = 8,
  parameter int unsigned CNTW   = 8
);
  localparam int unsigned LENW = $clog2(MAXLEN) + 1;

  logic              cfg_we;
  logic [MAXLEN-1:0] cfg_pattern;
  logic [LENW-1:0]   cfg_len;
  logic [CNTW-1:0]   cfg_target;
  logic              start;
  logic              abort;
  logic              in_valid;
  logic              in;
  logic              match;
  logic [CNTW-1:0]   match_count;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_target, start, abort, in_valid, in,
    input  match, match_count, busy, done, err
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_target, start, abort, in_valid, in,
    output match, match_count, busy, done, err
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Run-time configurable serial pattern detector: IDLE/RUN/DONE sequencing,
// overlapping match detection, saturating match counter and target stop.
module seq_detect_ctrl #(
  parameter int unsigned MAXLEN = 8,
  parameter int unsigned CNTW   = 8
) (
  input logic              clk,
  input logic              reset,
  seq_detect_ctrl_if.slave bus
);
  localparam int unsigned LENW = $clog2(MAXLEN) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            r_state;
  logic [MAXLEN-1:0] r_pattern;
  logic [LENW-1:0]   r_len;
  logic [CNTW-1:0]   r_target;
  // Oldest bit falls off the top; the newest bit is folded in via w_hist_next.
  logic [MAXLEN-2:0] r_hist;
  logic [LENW-1:0]   r_fill;
  logic [CNTW-1:0]   r_count;
  logic              r_match;
  logic              r_err;
  logic              r_busy;
  logic              r_done;

  logic [MAXLEN-1:0] w_mask;
  logic [MAXLEN-1:0] w_hist_next;
  logic [LENW-1:0]   w_fill_next;
  logic [CNTW-1:0]   w_count_next;
  logic              w_cfg_ok;
  logic              w_hit;
  logic              w_reach_target;

  // Select the low r_len bits for pattern comparison
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < int'(MAXLEN); i++) begin
      w_mask[i] = (i < int'(r_len));
    end
  end

  assign w_hist_next    = {r_hist, bus.in};
  assign w_fill_next    = (r_fill >= r_len) ? r_len : r_fill + 1'b1;
  assign w_hit          = (w_fill_next >= r_len) &&
                          ((w_hist_next & w_mask) == (r_pattern & w_mask));
  assign w_count_next   = (&r_count) ? r_count : r_count + 1'b1;
  assign w_reach_target = (r_target != '0) && (w_count_next == r_target);
  assign w_cfg_ok       = (bus.cfg_len != '0) && (bus.cfg_len <= LENW'(MAXLEN));

  // Config, sequencing and detection state with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_pattern <= MAXLEN'(4'b1010);
      r_len     <= LENW'(4);
      r_target  <= '0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_count   <= '0;
      r_match   <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_match <= 1'b0;
      r_err   <= 1'b0;

      // Config is only accepted outside a run and with a legal length
      if (bus.cfg_we) begin
        if ((r_state != StRun) && w_cfg_ok) begin
          r_pattern <= bus.cfg_pattern;
          r_len     <= bus.cfg_len;
          r_target  <= bus.cfg_target;
        end else begin
          r_err <= 1'b1;
        end
      end

      case (r_state)
        StIdle, StDone: begin
          // abort in IDLE/DONE is inert but still blocks a same-cycle start
          if (bus.start && !bus.abort) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_count <= '0;
            r_state <= StRun;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        StRun: begin
          if (bus.abort) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else if (bus.in_valid) begin
            r_hist <= w_hist_next[MAXLEN-2:0];
            r_fill <= w_fill_next;
            if (w_hit) begin
              r_match <= 1'b1;
              r_count <= w_count_next;
              if (w_reach_target) begin
                r_state <= StDone;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.match       = r_match;
  assign bus.match_count = r_count;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed, table-driven bench for seq_detect_ctrl with a few hand sequences.
module tb_seq_detect_ctrl;
  localparam int unsigned MAXLEN = 8;
  localparam int unsigned CNTW   = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seq_detect_ctrl_if #(.MAXLEN(MAXLEN), .CNTW(CNTW)) bus ();

  seq_detect_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       we;
    logic [7:0] pat;
    logic [3:0] len;
    logic [7:0] tgt;
    logic       start;
    logic       abort;
    logic       valid;
    logic       din;
    logic       e_match;
    logic [7:0] e_cnt;
    logic       e_busy;
    logic       e_done;
    logic       e_err;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic we, logic [7:0] pat, logic [3:0] len, logic [7:0] tgt,
                              logic start, logic abort, logic valid, logic din,
                              logic m, logic [7:0] cnt, logic busy, logic done, logic err);
    vec_t v;
    v.we = we; v.pat = pat; v.len = len; v.tgt = tgt;
    v.start = start; v.abort = abort; v.valid = valid; v.din = din;
    v.e_match = m; v.e_cnt = cnt; v.e_busy = busy; v.e_done = done; v.e_err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic m, input logic [7:0] cnt,
                            input logic busy, input logic done, input logic err);
    chk({tag, ".match"}, 32'(bus.match), 32'(m));
    chk({tag, ".count"}, 32'(bus.match_count), 32'(cnt));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(busy));
    chk({tag, ".done"}, 32'(bus.done), 32'(done));
    chk({tag, ".err"}, 32'(bus.err), 32'(err));
  endtask

  // Drive one cycle of inputs, clock it, then check 1 time unit after the edge
  task automatic apply(input vec_t v, input string tag);
    bus.cfg_we      = v.we;
    bus.cfg_pattern = v.pat;
    bus.cfg_len     = v.len;
    bus.cfg_target  = v.tgt;
    bus.start       = v.start;
    bus.abort       = v.abort;
    bus.in_valid    = v.valid;
    bus.in          = v.din;
    @(posedge clk);
    #1;
    check_outs(tag, v.e_match, v.e_cnt, v.e_busy, v.e_done, v.e_err);
  endtask

  initial begin
    // Order: we pat len tgt start abort valid din | match cnt busy done err
    // Default config 1010: overlapping matches after bits 4 and 6
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0, 0, 8'd0, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 0, 8'd0, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 0, 0, 8'd0, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 0, 8'd0, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 0, 1, 8'd1, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 0, 8'd1, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 0, 1, 8'd2, 1, 0, 0));
    // Config write during RUN rejected; detection continues with 1010
    vq.push_back(mk(1, 8'h03, 4'd2, 8'd3, 0, 0, 0, 0, 0, 8'd2, 1, 0, 1));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 0, 0, 8'd2, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 0, 8'd2, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 0, 1, 8'd3, 1, 0, 0));
    // Abort with a valid bit: no sample, count held; start+abort in IDLE inert
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 1, 1, 0, 0, 8'd3, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 1, 1, 0, 0, 0, 8'd3, 0, 0, 0));
    // Illegal lengths 0 and 9 rejected in IDLE
    vq.push_back(mk(1, 8'h03, 4'd0, 8'd0, 0, 0, 0, 0, 0, 8'd3, 0, 0, 1));
    vq.push_back(mk(1, 8'h03, 4'd9, 8'd1, 0, 0, 0, 0, 0, 8'd3, 0, 0, 1));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 0, 0, 8'd3, 0, 0, 0));
    // Pattern still 1010, no target
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0, 0, 8'd0, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 0, 8'd0, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 0, 0, 8'd0, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 0, 8'd0, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 0, 1, 8'd1, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 1, 0, 0, 0, 8'd1, 0, 0, 0));
    // Config 11/len2/target3 together with start; stop after third match
    vq.push_back(mk(1, 8'h03, 4'd2, 8'd3, 1, 0, 0, 0, 0, 8'd0, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 0, 8'd0, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 1, 8'd1, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 1, 8'd2, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 1, 8'd3, 0, 1, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 0, 8'd3, 0, 1, 0));
    // Config write in DONE accepted, stays DONE
    vq.push_back(mk(1, 8'h0A, 4'd4, 8'd0, 0, 0, 0, 0, 0, 8'd3, 0, 1, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 0, 0, 8'd3, 0, 1, 0));
    // 1,0, gap of 3 invalid cycles (in=1), 1,0 -> one match
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0, 0, 8'd0, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 0, 8'd0, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 0, 0, 8'd0, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 1, 0, 8'd0, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 1, 0, 8'd0, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 1, 0, 8'd0, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 0, 8'd0, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 0, 1, 8'd1, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 1, 0, 0, 0, 8'd1, 0, 0, 0));
    // 1,0,1 then abort on the completing bit: no match, count 0 held
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0, 0, 8'd0, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 0, 8'd0, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 0, 0, 8'd0, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 0, 8'd0, 1, 0, 0));
    vq.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 1, 1, 0, 0, 8'd0, 0, 0, 0));

    bus.cfg_we = 0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_target = '0;
    bus.start = 0; bus.abort = 0; bus.in_valid = 0; bus.in = 0;
    reset = 1'b1;
    #12;
    check_outs("reset", 0, 8'd0, 0, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i], $sformatf("vec%0d", i));
    end

    // Counter saturation: pattern '1', len 1, no target, 256 ones
    apply(mk(1, 8'h01, 4'd1, 8'd0, 1, 0, 0, 0, 0, 8'd0, 1, 0, 0), "sat.start");
    bus.cfg_we = 0; bus.start = 0; bus.in_valid = 1; bus.in = 1;
    for (int i = 0; i < 255; i++) @(posedge clk);
    #1;
    chk("sat.count255", 32'(bus.match_count), 32'hff);
    @(posedge clk);
    #1;
    chk("sat.hold", 32'(bus.match_count), 32'hff);
    chk("sat.pulse", 32'(bus.match), 32'd1);
    apply(mk(0, 8'h00, 4'd0, 8'd0, 0, 1, 0, 0, 0, 8'hff, 0, 0, 0), "sat.abort");

    // Reset mid-run with a match pulse outstanding, pattern 0110
    apply(mk(1, 8'h06, 4'd4, 8'd0, 1, 0, 0, 0, 0, 8'd0, 1, 0, 0), "rst.start");
    apply(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 0, 0, 8'd0, 1, 0, 0), "rst.b1");
    apply(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 0, 8'd0, 1, 0, 0), "rst.b2");
    apply(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 0, 8'd0, 1, 0, 0), "rst.b3");
    apply(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 0, 1, 8'd1, 1, 0, 0), "rst.b4");
    bus.in_valid = 0;
    #2;
    reset = 1'b1;
    #1;
    check_outs("rst.async", 0, 8'd0, 0, 0, 0);
    #2;
    reset = 1'b0;
    // Default 1010 must be back: stream 1010 gives one match
    apply(mk(0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0, 0, 8'd0, 1, 0, 0), "post.start");
    apply(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 0, 8'd0, 1, 0, 0), "post.b1");
    apply(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 0, 0, 8'd0, 1, 0, 0), "post.b2");
    apply(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1, 0, 8'd0, 1, 0, 0), "post.b3");
    apply(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 0, 1, 8'd1, 1, 0, 0), "post.b4");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
